sync_fifo: RTL and testbench
============================

# sync_fifo

Single-clock, parametrised FIFO, the synchronous successor of the dual-clock fifo_top. Width, depth and almost-full/almost-empty thresholds are parameters. It exposes an occupancy count and a registered read port with a read-valid strobe, and optionally keeps sticky overflow/underflow error flags. It sits between a producer and a consumer in the same clock domain and is driven by the existing inFIFO-style push/pop bench.

## Interface
- DATA_W, 8, data word width in bits (≥1)
- DEPTH, 16, number of entries; power of two, ≥4
- AF_LVL, DEPTH-2, almost_full asserts when count ≥ AF_LVL (1..DEPTH-1)
- AE_LVL, 2, almost_empty asserts when count ≤ AE_LVL (0..DEPTH-2)
- Derived localparams: ADDR_W = $clog2(DEPTH), CNT_W = ADDR_W+1

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- push  in  1  write request
- data_in  in  DATA_W  write data, sampled with accepted push
- full  out  1  count == DEPTH
- almost_full  out  1  count ≥ AF_LVL
- pop  in  1  read request
- data_out  out  DATA_W  registered read data
- rd_valid  out  1  one-cycle strobe: data_out updated this cycle
- empty  out  1  count == 0
- almost_empty  out  1  count ≤ AE_LVL
- count  out  CNT_W  current occupancy, 0..DEPTH
- overflow  out  1  sticky: push attempted while full (SFIFO_ERR_EN only)
- underflow  out  1  sticky: pop attempted while empty (SFIFO_ERR_EN only)
- err_clr  in  1  clears overflow/underflow (SFIFO_ERR_EN only)

## Operation
- Acceptance is evaluated on the registered flags at the clock edge:
  - wr_acc = push & !full
  - rd_acc = pop & !empty
- Accepted push: mem[wr_ptr] ← data_in; wr_ptr increments modulo DEPTH.
- Accepted pop: data_out ← mem[rd_ptr]; rd_ptr increments modulo DEPTH; rd_valid=1 next cycle.
- Count update:
  - count += 1 if wr_acc & !rd_acc
  - count -= 1 if rd_acc & !wr_acc
  - unchanged if both or neither
- Pointers are ADDR_W bits wide and wrap naturally. full/empty are derived from count, never from pointer comparison.
- Push while full: rejected even if pop is also asserted; no memory write; overflow sets.
- Pop while empty: rejected even if push is also asserted. The push is still accepted. underflow sets.
- Push+pop when neither full nor empty: both accepted, count unchanged. Read returns the oldest entry, never the word being written.
- data_out holds its last value when no pop is accepted. rd_valid=0.
- Flags and count are registered; they all change on the same edge as count.
- Reset values: count=0, empty=1, almost_empty=1, full=0, almost_full=0, data_out=0, rd_valid=0, overflow=0, underflow=0, both pointers 0.
- Reset mid-operation: all contents are logically discarded; memory array is not cleared. rst has priority over push/pop/err_clr.

## Timing
- Write latency: push accepted at edge N makes empty deassert after N. Pop at edge N+1 returns the word, with rd_valid high in cycle N+1..N+2.
- Read latency: 1 cycle from accepted pop to data_out/rd_valid.
- Throughput: one push and one pop per cycle, sustained.
- Error flags set on the edge of the offending request. err_clr clears on its edge; a simultaneous error event wins (flag stays 1).

## Configuration
- SFIFO_ERR_EN defined:
  - overflow/underflow sticky registers and err_clr are implemented.
- Undefined:
  - overflow and underflow are tied to 0.
  - err_clr is ignored.
  - no error registers are synthesised.
  - push/pop rejection behaviour is identical in both cases.

## Structure
- Package sfifo_pkg holds:
  - default DATA_W/DEPTH constants
  - function for CNT_W
  - typedef of the flag struct {full, almost_full, empty, almost_empty}, used by bench and RTL
- Sub-module sfifo_mem: DEPTH×DATA_W register array with one write port and one registered read port (we, waddr, wdata, re, raddr, rdata). sync_fifo holds pointers, count, flags and error logic.

## Test plan
- Reset then idle: after rst deasserts, count=0, empty=1, almost_empty=1, full=0, data_out=0, rd_valid=0.
- Fill with DEPTH=16: push 0x00..0x0F in 16 cycles. Expect:
  - almost_full after the 14th push
  - full after the 16th push, count=16
  - a 17th push of 0xAA is rejected and overflow=1 (ERR_EN)
- Drain: pop 16 times. Expect data_out 0x00..0x0F in order, each with rd_valid, 1 cycle after pop. Then a 17th pop gives rd_valid=0, data_out held at 0x0F, underflow=1.
- Wrap-around: 10 pushes, 10 pops, then 12 pushes/12 pops with simultaneous push+pop at count=5. Order is preserved and count holds 5 during concurrent cycles.
- Boundary collisions:
  - push+pop when empty: push accepted, count=1, underflow=1, rd_valid=0
  - push+pop when full: pop accepted, push rejected, count=15, overflow=1
- err_clr and mid-operation reset: err_clr clears both flags. rst at count=7 gives count=0, empty=1. The next push 0x55 and pop returns 0x55.

Source files
------------

// File: rtl/sfifo_pkg.sv
// -----------------------------------------------------------------------------
// sfifo_pkg
// Shared definitions for the single-clock FIFO (sync_fifo) and its bench.
//   - DEF_DATA_W / DEF_DEPTH : default word width and entry count
//   - cnt_w()                : width of an occupancy counter able to hold 0..DEPTH
//   - sfifo_flags_t          : registered status flags, shared by RTL and bench
// -----------------------------------------------------------------------------
package sfifo_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 16;

  // Occupancy needs one bit more than the address so that "full" (== DEPTH)
  // is representable.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  typedef struct packed {
    logic full;
    logic almost_full;
    logic empty;
    logic almost_empty;
  } sfifo_flags_t;

endpackage

// File: rtl/sfifo_mem.sv
// -----------------------------------------------------------------------------
// sfifo_mem
// DEPTH x DATA_W register array, one write port, one registered read port.
// Ports:
//   clk            rising-edge clock
//   rst            synchronous active-high reset (clears rdata only)
//   we/waddr/wdata write enable, address, data
//   re/raddr       read enable, address
//   rdata          registered read data, holds when re is low
// -----------------------------------------------------------------------------
module sfifo_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // NOTE: the storage array has no reset; stale contents are unreachable once
  // the pointers and count are reset, and leaving it unreset keeps it mappable
  // to plain flops or RAM without a clear path.
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (re) begin
      r_rdata <= r_mem[raddr];
    end
  end

  assign rdata = r_rdata;

endmodule

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock parametrised FIFO with occupancy count, registered status flags
// and a registered read port with a one-cycle read-valid strobe.
// Optional feature macro: SFIFO_ERR_EN -- when defined, sticky overflow and
// underflow flags plus err_clr are implemented; otherwise both flags are 0
// and err_clr is ignored.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   push, data_in         write request and data
//   pop                   read request
//   data_out, rd_valid    registered read data and its one-cycle strobe
//   full, almost_full     count == DEPTH, count >= AF_LVL
//   empty, almost_empty   count == 0,     count <= AE_LVL
//   count                 occupancy 0..DEPTH
//   overflow, underflow   sticky error flags
//   err_clr               clears the sticky error flags
// -----------------------------------------------------------------------------
module sync_fifo
  import sfifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int AF_LVL = DEPTH - 2,
  parameter int AE_LVL = 2,
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int CNT_W  = cnt_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] data_in,
  output logic              full,
  output logic              almost_full,
  input  logic              pop,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
  output logic              empty,
  output logic              almost_empty,
  output logic [CNT_W-1:0]  count,
  output logic              overflow,
  output logic              underflow,
  input  logic              err_clr
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_LVL);
  localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_LVL);

  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  sfifo_flags_t      r_flags;
  logic              r_rd_valid;

  logic              w_wr_acc;
  logic              w_rd_acc;
  logic [CNT_W-1:0]  w_cnt_nxt;
  sfifo_flags_t      w_flags_nxt;

  // Acceptance uses the registered flags, so a push on a full FIFO is refused
  // even when a pop frees a slot on the same edge (and likewise for pop/empty).
  assign w_wr_acc = push & ~r_flags.full;
  assign w_rd_acc = pop  & ~r_flags.empty;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned (which would infer a latch); combinational code uses '='.
  always_comb begin
    w_cnt_nxt = r_count;
    unique case ({w_wr_acc, w_rd_acc})
      2'b10:   w_cnt_nxt = r_count + CNT_W'(1);
      2'b01:   w_cnt_nxt = r_count - CNT_W'(1);
      default: w_cnt_nxt = r_count;
    endcase
  end

  // Flags are computed from the next count and registered with it, so count
  // and all four flags change on the same edge.
  always_comb begin
    w_flags_nxt.full         = (w_cnt_nxt == DEPTH_C);
    w_flags_nxt.almost_full  = (w_cnt_nxt >= AF_C);
    w_flags_nxt.empty        = (w_cnt_nxt == '0);
    w_flags_nxt.almost_empty = (w_cnt_nxt <= AE_C);
  end

  // NOTE: sequential state uses non-blocking '<=' so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_flags    <= '{full: 1'b0, almost_full: 1'b0, empty: 1'b1, almost_empty: 1'b1};
      r_rd_valid <= 1'b0;
    end else begin
      r_count    <= w_cnt_nxt;
      r_flags    <= w_flags_nxt;
      r_rd_valid <= w_rd_acc;
      // DEPTH is a power of two, so the pointers wrap by plain overflow.
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
    end
  end

  // A same-address read/write cannot occur: the pointers only coincide when
  // empty (pop refused) or full (push refused).
  sfifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (w_wr_acc),
    .waddr (r_wr_ptr),
    .wdata (data_in),
    .re    (w_rd_acc),
    .raddr (r_rd_ptr),
    .rdata (data_out)
  );

`ifdef SFIFO_ERR_EN
  logic r_overflow;
  logic r_underflow;

  // A new error event on the same edge as err_clr keeps the flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= (push & r_flags.full)  | (r_overflow  & ~err_clr);
      r_underflow <= (pop  & r_flags.empty) | (r_underflow & ~err_clr);
    end
  end

  assign overflow  = r_overflow;
  assign underflow = r_underflow;
`else
  logic w_unused_err_clr;
  assign w_unused_err_clr = err_clr;
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

  assign count        = r_count;
  assign full         = r_flags.full;
  assign almost_full  = r_flags.almost_full;
  assign empty        = r_flags.empty;
  assign almost_empty = r_flags.almost_empty;
  assign rd_valid     = r_rd_valid;

endmodule

// File: tb/tb_sync_fifo.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo
// Scoreboard bench for sync_fifo. A queue-based reference model is stepped on
// every rising edge with the stimulus just applied; accepted reads push their
// expected word into a scoreboard queue that a separate monitor drains on the
// falling edge whenever rd_valid is high. Honours SFIFO_ERR_EN like the RTL.
// -----------------------------------------------------------------------------
module tb_sync_fifo;
  import sfifo_pkg::*;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int AF_LVL = DEPTH - 2;
  localparam int AE_LVL = 2;
  localparam int CNT_W  = cnt_w(DEPTH);

  logic              clk = 1'b0;
  logic              rst;
  logic              push;
  logic [DATA_W-1:0] data_in;
  logic              pop;
  logic              err_clr;
  logic              full, almost_full, empty, almost_empty;
  logic [DATA_W-1:0] data_out;
  logic              rd_valid;
  logic [CNT_W-1:0]  count;
  logic              overflow, underflow;

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AF_LVL (AF_LVL),
    .AE_LVL (AE_LVL)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .push         (push),
    .data_in      (data_in),
    .full         (full),
    .almost_full  (almost_full),
    .pop          (pop),
    .data_out     (data_out),
    .rd_valid     (rd_valid),
    .empty        (empty),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow),
    .err_clr      (err_clr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [DATA_W-1:0] mq[$];     // FIFO contents, oldest at front
  logic [DATA_W-1:0] sb_q[$];   // reads the DUT owes us
  logic [DATA_W-1:0] m_dout = '0;
  logic              m_ovf  = 1'b0;
  logic              m_udf  = 1'b0;
  bit                mon_en = 1'b0;

`ifdef SFIFO_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of model behaviour, using the occupancy before the edge.
  task automatic model_step(input logic p, input logic q, input logic [DATA_W-1:0] d,
                            input logic c, input logic r);
    bit was_full, was_empty;
    if (r) begin
      mq.delete();
      m_dout = '0;
      m_ovf  = 1'b0;
      m_udf  = 1'b0;
      return;
    end
    was_full  = (mq.size() == DEPTH);
    was_empty = (mq.size() == 0);
    if (ERR_EN) begin
      m_ovf = (p && was_full)  || (m_ovf && !c);
      m_udf = (q && was_empty) || (m_udf && !c);
    end
    if (q && !was_empty) begin
      m_dout = mq.pop_front();
      sb_q.push_back(m_dout);
    end
    if (p && !was_full) mq.push_back(d);
  endtask

  task automatic cycle(input logic p, input logic q, input logic [DATA_W-1:0] d,
                       input logic c = 1'b0, input logic r = 1'b0);
    push = p; pop = q; data_in = d; err_clr = c; rst = r;
    @(posedge clk);
    model_step(p, q, d, c, r);
    @(negedge clk);
  endtask

  // Monitor: compares DUT outputs against the model away from the active edge.
  initial begin
    sfifo_flags_t exp_f, act_f;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (rd_valid) begin
          if (sb_q.size() == 0) check("rd_valid_unexpected", 32'(rd_valid), 32'd0);
          else                  check("rd_data", 32'(data_out), 32'(sb_q.pop_front()));
        end
        check("rd_valid_missing", sb_q.size(), 0);
        sb_q.delete();
        check("dout_hold", 32'(data_out), 32'(m_dout));
        check("count", 32'(count), mq.size());
        exp_f.full         = (mq.size() == DEPTH);
        exp_f.almost_full  = (mq.size() >= AF_LVL);
        exp_f.empty        = (mq.size() == 0);
        exp_f.almost_empty = (mq.size() <= AE_LVL);
        act_f = '{full: full, almost_full: almost_full, empty: empty, almost_empty: almost_empty};
        check("flags", 32'(act_f), 32'(exp_f));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("underflow", 32'(underflow), 32'(m_udf));
      end
    end
  end

  initial begin
    push = 1'b0; pop = 1'b0; data_in = '0; err_clr = 1'b0; rst = 1'b1;

    // Reset then idle
    cycle(0, 0, 8'h00, 0, 1);
    mon_en = 1'b1;
    cycle(0, 0, 8'h00, 0, 1);
    cycle(0, 0, 8'h00);
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_almost_empty", 32'(almost_empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_data_out", 32'(data_out), 32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);

    // Fill 0x00..0x0F
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1, 0, 8'(i));
      if (i == 12) check("af_after_13", 32'(almost_full), 32'd0);
      if (i == 13) check("af_after_14", 32'(almost_full), 32'd1);
      if (i == 14) check("full_after_15", 32'(full), 32'd0);
    end
    check("fill_full", 32'(full), 32'd1);
    check("fill_count", 32'(count), 32'd16);
    cycle(1, 0, 8'hAA);
    check("push_full_count", 32'(count), 32'd16);
    check("push_full_ovf", 32'(overflow), 32'(ERR_EN));

    // Drain in order
    for (int i = 0; i < DEPTH; i++) begin
      cycle(0, 1, 8'h00);
      check("drain_data", 32'(data_out), 32'(i));
      check("drain_valid", 32'(rd_valid), 32'd1);
    end
    cycle(0, 1, 8'h00);
    check("pop_empty_valid", 32'(rd_valid), 32'd0);
    check("pop_empty_hold", 32'(data_out), 32'h0F);
    check("pop_empty_udf", 32'(underflow), 32'(ERR_EN));
    cycle(0, 0, 8'h00, 1);
    check("err_clr_ovf", 32'(overflow), 32'd0);
    check("err_clr_udf", 32'(underflow), 32'd0);

    // Wrap-around and sustained push+pop at count 5
    for (int i = 0; i < 10; i++) cycle(1, 0, 8'(8'h20 + i));
    for (int i = 0; i < 10; i++) cycle(0, 1, 8'h00);
    for (int i = 0; i < 5; i++)  cycle(1, 0, 8'(8'h40 + i));
    for (int i = 0; i < 12; i++) begin
      cycle(1, 1, 8'(8'h50 + i));
      check("concurrent_count", 32'(count), 32'd5);
    end
    for (int i = 0; i < 5; i++)  cycle(0, 1, 8'h00);

    // Boundary collisions
    cycle(1, 1, 8'h66);
    check("pp_empty_count", 32'(count), 32'd1);
    check("pp_empty_valid", 32'(rd_valid), 32'd0);
    check("pp_empty_udf", 32'(underflow), 32'(ERR_EN));
    for (int i = 0; i < DEPTH - 1; i++) cycle(1, 0, 8'(8'h70 + i));
    cycle(1, 1, 8'hEE);
    check("pp_full_count", 32'(count), 32'd15);
    check("pp_full_ovf", 32'(overflow), 32'(ERR_EN));
    check("pp_full_data", 32'(data_out), 32'h66);

    // err_clr, then mid-operation reset at count 7
    cycle(0, 0, 8'h00, 1);
    for (int i = 0; i < 15; i++) cycle(0, 1, 8'h00);
    for (int i = 0; i < 7; i++)  cycle(1, 0, 8'(8'h90 + i));
    check("pre_rst_count", 32'(count), 32'd7);
    cycle(1, 1, 8'h33, 1, 1);
    check("mid_rst_count", 32'(count), 32'd0);
    check("mid_rst_empty", 32'(empty), 32'd1);
    cycle(1, 0, 8'h55);
    cycle(0, 1, 8'h00);
    check("post_rst_data", 32'(data_out), 32'h55);

    // Randomised traffic with push-heavy then pop-heavy bias
    for (int i = 0; i < 600; i++) begin
      int pw, pr;
      pw = (i < 300) ? 65 : 40;
      pr = (i < 300) ? 40 : 65;
      cycle($urandom_range(0, 99) < pw, $urandom_range(0, 99) < pr, 8'($urandom),
            $urandom_range(0, 99) < 5, $urandom_range(0, 199) == 0);
    end

    for (int i = 0; i < DEPTH + 2; i++) cycle(0, 1, 8'h00);
    check("final_empty", 32'(empty), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
